// File: rtl/method_call_initiator.sv
// Caller side of the generated-method handshake (req / busy / return).
// A one-cycle start in IDLE issues one call. The initiator then waits for the callee to
// finish, captures the return value, and reports done (with timeout if the call was aborted).
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start, arg        request one call (sampled only when idle) and its argument
//   active            high while a call is in flight
//   done              one-cycle pulse when a call ends (normal or aborted)
//   timeout           set with done on abort; held until the next accepted start
//   result            return value of the last successful call
//   call_count        number of successful calls (wraps)
//   m_req, m_arg      request and argument driven to the callee
//   m_busy, m_return  callee busy flag and return value
module method_call_initiator #(
  parameter int unsigned ARG_WIDTH      = 32,
  parameter int unsigned RET_WIDTH      = 32,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ARG_WIDTH-1:0] arg,
  output logic                 active,
  output logic                 done,
  output logic                 timeout,
  output logic [RET_WIDTH-1:0] result,
  output logic [15:0]          call_count,
  output logic                 m_req,
  output logic [ARG_WIDTH-1:0] m_arg,
  input  logic                 m_busy,
  input  logic [RET_WIDTH-1:0] m_return
);

  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e        state;
  logic [31:0]   elapsed;
  logic [GW-1:0] gcnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= StIdle;
      elapsed    <= 32'd0;
      gcnt       <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      result     <= '0;
      call_count <= 16'd0;
      m_req      <= 1'b0;
      m_arg      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          // m_busy is deliberately ignored here.
          if (start) begin
            m_arg   <= arg;
            m_req   <= 1'b1;
            timeout <= 1'b0;
            active  <= 1'b1;
            elapsed <= 32'd1;
            gcnt    <= GW'(1);
            state   <= StReq;
          end
        end
        StReq: begin
          elapsed <= elapsed + 32'd1;
          // The guard limit lets a callee that never shows busy (zero latency) still complete.
          if (m_busy || (gcnt == GW'(GUARD_CYCLES))) begin
            m_req <= 1'b0;
            state <= StWait;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        StWait: begin
          // Success takes priority over a timeout that falls in the same cycle.
          if (!m_busy) begin
            result     <= m_return;
            done       <= 1'b1;
            active     <= 1'b0;
            call_count <= call_count + 16'd1;
            state      <= StIdle;
          end else if (elapsed == TIMEOUT_CYCLES) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            active  <= 1'b0;
            state   <= StIdle;
          end else begin
            elapsed <= elapsed + 32'd1;
          end
        end
        default: begin
          m_req  <= 1'b0;
          active <= 1'b0;
          state  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_method_call_initiator.sv
// Self-checking bench for method_call_initiator. Each call is described by a callee busy
// script: busy is high for cycles rise..fall-1 counted from the issue edge. From that script
// the bench works out, in closed form, how long the request lasts, when done fires and
// whether the call times out. It then checks every output after every edge.
module tb_method_call_initiator;

  localparam int GUARD   = 4;
  localparam int TIMEOUT = 50;
  localparam int NEVER   = 1 << 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] arg = 32'd0;
  logic        active, done, timeout, m_req;
  logic [31:0] result, m_arg;
  logic [15:0] call_count;
  logic        m_busy = 1'b0;
  logic [31:0] m_return = 32'd0;

  method_call_initiator #(
    .ARG_WIDTH(32),
    .RET_WIDTH(32),
    .GUARD_CYCLES(GUARD),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .arg(arg),
    .active(active),
    .done(done),
    .timeout(timeout),
    .result(result),
    .call_count(call_count),
    .m_req(m_req),
    .m_arg(m_arg),
    .m_busy(m_busy),
    .m_return(m_return)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Values the outputs must hold between calls.
  logic        exp_timeout = 1'b0;
  logic [31:0] exp_result = 32'd0;
  logic [15:0] exp_count = 16'd0;
  logic [31:0] exp_arg = 32'd0;

  // Observations from the most recent call, used by the literal pins.
  int req_seen;
  int done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input bit e_active, input bit e_done, input bit e_req);
    chk("active", 32'(active), 32'(e_active));
    chk("done", 32'(done), 32'(e_done));
    chk("m_req", 32'(m_req), 32'(e_req));
    chk("timeout", 32'(timeout), 32'(exp_timeout));
    chk("result", result, exp_result);
    chk("call_count", 32'(call_count), 32'(exp_count));
    chk("m_arg", m_arg, exp_arg);
  endtask

  function automatic bit bz(input int k, input int r, input int f);
    return (k >= r) && (k < f);
  endfunction

  // Issue one call and follow it to the end.
  // r/f: busy script; gap: idle cycles afterwards; ab: edge at which reset hits (0 = none).
  task automatic run_call(input logic [31:0] a, input logic [31:0] ret, input int r,
                          input int f, input int gap, input int ab);
    int  q;
    int  d;
    bit  is_to;
    // The request ends when busy is first seen, or at the guard limit.
    q = (r <= GUARD) ? r : GUARD;
    d = -1;
    for (int k = q + 1; k <= TIMEOUT; k++) begin
      if (!bz(k, r, f)) begin
        d = k;
        break;
      end
    end
    is_to = (d < 0);
    if (is_to) d = TIMEOUT;

    req_seen  = 0;
    done_seen = 0;
    start     = 1'b1;
    arg       = a;
    m_return  = ret;
    for (int k = 0; k <= d; k++) begin
      @(posedge clk);
      #1;
      if (ab != 0 && k == ab) begin
        exp_timeout = 1'b0;
        exp_result  = 32'd0;
        exp_count   = 16'd0;
        exp_arg     = 32'd0;
        check_all(1'b0, 1'b0, 1'b0);
        reset  = 1'b1;
        start  = 1'b0;
        m_busy = 1'b0;
        return;
      end
      if (m_req) req_seen++;
      if (done) done_seen++;
      exp_arg     = a;
      exp_timeout = (k == d) ? is_to : 1'b0;
      if (k == d && !is_to) begin
        exp_result = ret;
        exp_count  = exp_count + 16'd1;
      end
      check_all(k < d, k == d, k < q);
      if (k < d) begin
        // Starts and argument changes during a call must be ignored.
        start    = 1'($urandom_range(0, 1));
        arg      = $urandom;
        m_busy   = bz(k + 1, r, f);
        m_return = m_busy ? $urandom : ret;
        if (ab != 0 && k + 1 == ab) reset = 1'b0;
      end
    end
    start = 1'b0;
    for (int g = 0; g < gap; g++) begin
      m_busy   = 1'($urandom_range(0, 1));
      m_return = $urandom;
      arg      = $urandom;
      @(posedge clk);
      #1;
      check_all(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int r;
    int f;
    // Reset held with start asserted: nothing may be issued.
    reset = 1'b0;
    start = 1'b1;
    arg   = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_all(1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;

    // Busy rises after two cycles and is held for ten; gap 0 makes the next start back-to-back.
    run_call(32'h0000_1234, 32'd1, 3, 13, 0, 0);
    chk("pin_result_1", result, 32'd1);
    chk("pin_count_1", 32'(call_count), 32'd1);
    chk("pin_timeout_1", 32'(timeout), 32'd0);
    chk("pin_arg_1", m_arg, 32'h0000_1234);
    chk("pin_req_cycles_1", 32'(req_seen), 32'd3);
    chk("pin_done_pulses_1", 32'(done_seen), 32'd1);

    // Callee never raises busy: request held exactly for the guard limit.
    run_call(32'h55, 32'hCAFE, NEVER, NEVER + 1, 1, 0);
    chk("pin_req_cycles_2", 32'(req_seen), 32'd4);
    chk("pin_result_2", result, 32'hCAFE);
    chk("pin_count_2", 32'(call_count), 32'd2);

    // Busy forever: abort at the timeout limit, result and count unchanged.
    run_call(32'h77, 32'hBEEF, 1, NEVER, 2, 0);
    chk("pin_timeout_3", 32'(timeout), 32'd1);
    chk("pin_result_3", result, 32'hCAFE);
    chk("pin_count_3", 32'(call_count), 32'd2);
    chk("pin_done_pulses_3", 32'(done_seen), 32'd1);

    // Busy falls exactly at the timeout limit: success wins.
    run_call(32'h99, 32'hAAAA, 2, TIMEOUT, 0, 0);
    chk("pin_timeout_4", 32'(timeout), 32'd0);
    chk("pin_result_4", result, 32'hAAAA);
    chk("pin_count_4", 32'(call_count), 32'd3);

    // One cycle later is too late.
    run_call(32'h9A, 32'hBBBB, 2, TIMEOUT + 1, 1, 0);
    chk("pin_timeout_5", 32'(timeout), 32'd1);
    chk("pin_count_5", 32'(call_count), 32'd3);

    // Randomized calls.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 7);
      if ($urandom_range(0, 7) == 0) r = NEVER;
      f = (r == NEVER) ? NEVER + 1 : r + $urandom_range(1, 8);
      if (r != NEVER && $urandom_range(0, 9) == 0) f = NEVER;
      run_call($urandom, $urandom, r, f, $urandom_range(0, 3), 0);
    end

    // Reset during the wait phase: everything cleared, no done.
    run_call(32'h4242, 32'h1111, 1, NEVER, 0, 10);
    chk("pin_count_rst", 32'(call_count), 32'd0);
    chk("pin_req_rst", 32'(m_req), 32'd0);
    chk("pin_done_pulses_rst", 32'(done_seen), 32'd0);

    run_call(32'h5151, 32'h2222, 2, 4, 1, 0);
    chk("pin_count_after_rst", 32'(call_count), 32'd1);
    chk("pin_result_after_rst", result, 32'h2222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
